task_fsm_array: RTL and testbench

Parametrised per-task control block for the generated top-level. It sits between the global FSM and `N_TASKS` task instances and drives the ap_start/ap_ready/ap_done/ap_idle handshake for each task. Each task can be invoked a programmable number of times per global run. Scalars are latched at global start, and the block reports per-task and aggregate completion back to the global FSM.

---
 rtl/task_fsm_array.sv | 142 ++++++++++++++
 tb/tb_task_fsm_array.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_fsm_array.sv
// task_fsm_array
// Per-task control block that sits between the global FSM and N_TASKS task
// instances. It drives the ap_start/ap_ready/ap_done handshake for each task
// and runs each task a programmable number of times per global run.
//
// Optional feature macro: TASK_FSM_PERF_EN adds per-channel 32-bit busy-cycle
// counters on task_busy_cycles. Without it, the port and counters are absent.
//
// Ports:
//   ap_clk, ap_rst            clock, async active-high reset
//   global_fsm_ap_start       global run start (level)
//   global_fsm_ap_done        releases channels parked in DONE
//   global_fsm_s_scalar       per-task scalar, latched at start
//   global_fsm_s_iters        invocations per task per run
//   global_fsm_task_mask      per-channel enable (0 = skip)
//   task_s_scalar             latched scalar per task
//   task_ap_start             start to each task
//   task_ap_ready/done/idle   task handshake inputs (idle is observed only)
//   to_global_fsm_is_done     channel in DONE
//   to_global_fsm_all_done    all channels in DONE
//   task_busy_cycles          per-channel busy counters (perf build only)
module task_fsm_array #(
    parameter int N_TASKS  = 4,
    parameter int SCALAR_W = 64,
    parameter int CNT_W    = 16
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         global_fsm_ap_start,
    input  logic                         global_fsm_ap_done,
    input  logic [N_TASKS*SCALAR_W-1:0]  global_fsm_s_scalar,
    input  logic [CNT_W-1:0]             global_fsm_s_iters,
    input  logic [N_TASKS-1:0]           global_fsm_task_mask,
    output logic [N_TASKS*SCALAR_W-1:0]  task_s_scalar,
    output logic [N_TASKS-1:0]           task_ap_start,
    input  logic [N_TASKS-1:0]           task_ap_ready,
    input  logic [N_TASKS-1:0]           task_ap_done,
    input  logic [N_TASKS-1:0]           task_ap_idle,
    output logic [N_TASKS-1:0]           to_global_fsm_is_done,
    output logic                         to_global_fsm_all_done
`ifdef TASK_FSM_PERF_EN
    ,
    output logic [N_TASKS*32-1:0]        task_busy_cycles
`endif
);

    // state | meaning
    // IDLE  | waiting for global start
    // START | task_ap_start high, waiting for ready
    // WAIT  | start accepted, waiting for done
    // DONE  | all invocations finished, waiting for global done
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_WAIT  = 2'b11,
        S_DONE  = 2'b10
    } state_t;

    state_t                state    [N_TASKS];
    logic [CNT_W-1:0]      rem      [N_TASKS];
    logic [SCALAR_W-1:0]   scalar_q [N_TASKS];

    // task_ap_idle is informational only; fold it into a sink to keep it visible.
    logic idle_unused;
    assign idle_unused = ^task_ap_idle;

    for (genvar i = 0; i < N_TASKS; i++) begin : g_ch
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                state[i]    <= S_IDLE;
                rem[i]      <= '0;
                scalar_q[i] <= '0;
            end else begin
                case (state[i])
                    S_IDLE: begin
                        if (global_fsm_ap_start) begin
                            scalar_q[i] <= global_fsm_s_scalar[i*SCALAR_W +: SCALAR_W];
                            rem[i]      <= global_fsm_s_iters;
                            if (!global_fsm_task_mask[i] || (global_fsm_s_iters == '0))
                                state[i] <= S_DONE;
                            else
                                state[i] <= S_START;
                        end
                    end
                    S_START: begin
                        if (task_ap_ready[i]) begin
                            // Ready and done in one cycle completes an invocation
                            // and keeps start asserted for the next one.
                            if (task_ap_done[i]) begin
                                if (rem[i] == CNT_W'(1))
                                    state[i] <= S_DONE;
                                else
                                    rem[i] <= rem[i] - CNT_W'(1);
                            end else begin
                                state[i] <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (task_ap_done[i]) begin
                            if (rem[i] == CNT_W'(1)) begin
                                state[i] <= S_DONE;
                            end else begin
                                rem[i]   <= rem[i] - CNT_W'(1);
                                state[i] <= S_START;
                            end
                        end
                    end
                    S_DONE: begin
                        // Global done wins over a concurrent start; the start is
                        // only taken once the channel is back in IDLE.
                        if (global_fsm_ap_done)
                            state[i] <= S_IDLE;
                    end
                    default: state[i] <= S_IDLE;
                endcase
            end
        end

        assign task_s_scalar[i*SCALAR_W +: SCALAR_W] = scalar_q[i];
        assign task_ap_start[i]         = (state[i] == S_START);
        assign to_global_fsm_is_done[i] = (state[i] == S_DONE);

`ifdef TASK_FSM_PERF_EN
        logic [31:0] busy;
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst) begin
                busy <= '0;
            end else if ((state[i] == S_IDLE) && global_fsm_ap_start) begin
                busy <= '0;
            end else if (((state[i] == S_START) || (state[i] == S_WAIT)) &&
                         (busy != 32'hFFFF_FFFF)) begin
                busy <= busy + 32'd1;
            end
        end
        assign task_busy_cycles[i*32 +: 32] = busy;
`endif
    end

    assign to_global_fsm_all_done = &to_global_fsm_is_done;

endmodule

// File: tb/tb_task_fsm_array.sv
module tb_task_fsm_array;

    localparam int N  = 4;
    localparam int SW = 64;
    localparam int CW = 16;

    logic            ap_clk;
    logic            ap_rst;
    logic            g_start;
    logic            g_done;
    logic [N*SW-1:0] g_scalar;
    logic [CW-1:0]   g_iters;
    logic [N-1:0]    g_mask;
    logic [N*SW-1:0] t_scalar;
    logic [N-1:0]    t_start;
    logic [N-1:0]    t_ready;
    logic [N-1:0]    t_done;
    logic [N-1:0]    t_idle;
    logic [N-1:0]    is_done;
    logic            all_done;
`ifdef TASK_FSM_PERF_EN
    logic [N*32-1:0] busy;
`endif

    task_fsm_array #(.N_TASKS(N), .SCALAR_W(SW), .CNT_W(CW)) dut (
        .ap_clk                 (ap_clk),
        .ap_rst                 (ap_rst),
        .global_fsm_ap_start    (g_start),
        .global_fsm_ap_done     (g_done),
        .global_fsm_s_scalar    (g_scalar),
        .global_fsm_s_iters     (g_iters),
        .global_fsm_task_mask   (g_mask),
        .task_s_scalar          (t_scalar),
        .task_ap_start          (t_start),
        .task_ap_ready          (t_ready),
        .task_ap_done           (t_done),
        .task_ap_idle           (t_idle),
        .to_global_fsm_is_done  (is_done),
        .to_global_fsm_all_done (all_done)
`ifdef TASK_FSM_PERF_EN
        ,
        .task_busy_cycles       (busy)
`endif
    );

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] obs);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_underflow", 64'(sbq.size()), 64'd1);
        end else begin
            e = sbq.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    logic [N-1:0] start_or;
    int           n_start;

    initial begin
        ap_rst   = 1'b1;
        g_start  = 1'b0;
        g_done   = 1'b0;
        g_scalar = '0;
        g_iters  = '0;
        g_mask   = '0;
        t_ready  = '0;
        t_done   = '0;
        t_idle   = '1;
        tick();
        tick();

        // reset state
        push("rst_start", 64'h0);
        push("rst_is_done", 64'h0);
        push("rst_all_done", 64'h0);
        push("rst_scalar", 64'h0);
        pop_chk(64'(t_start));
        pop_chk(64'(is_done));
        pop_chk(64'(all_done));
        pop_chk(t_scalar[63:0]);
        ap_rst = 1'b0;
        tick();

        // single task iters=1, with scalar hold
        g_mask           = 4'b0001;
        g_iters          = 16'd1;
        g_scalar[63:0]   = 64'h0000_0000_DEAD_BEEF;
        g_start          = 1'b1;
        push("s1_start", 64'b0001);
        push("s1_skip_done", 64'b1110);
        tick();
        g_start = 1'b0;
        pop_chk(64'(t_start));
        pop_chk(64'(is_done));
        t_ready = 4'b0001;
        push("s1_wait_start", 64'b0000);
        tick();
        t_ready = 4'b0000;
        pop_chk(64'(t_start));
        // change the input scalar and pulse start while busy: both ignored
        g_scalar[63:0] = 64'h1234_5678_9ABC_DEF0;
        g_start        = 1'b1;
        tick();
        g_start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        push("s1_scalar_hold", 64'h0000_0000_DEAD_BEEF);
        push("s1_not_done", 64'b1110);
        pop_chk(t_scalar[63:0]);
        pop_chk(64'(is_done));
        t_done = 4'b0001;
        push("s1_is_done", 64'b1111);
        push("s1_all_done", 64'h1);
        push("s1_scalar_done", 64'h0000_0000_DEAD_BEEF);
        tick();
        t_done = 4'b0000;
        pop_chk(64'(is_done));
        pop_chk(64'(all_done));
        pop_chk(t_scalar[63:0]);
        g_done = 1'b1;
        push("s1_release", 64'b0000);
        tick();
        g_done = 1'b0;
        pop_chk(64'(is_done));

        // done-to-restart gap is one cycle (iters=2 via WAIT)
        g_iters = 16'd2;
        g_start = 1'b1;
        tick();
        g_start = 1'b0;
        t_ready = 4'b0001;
        tick();
        t_ready = 4'b0000;
        t_done  = 4'b0001;
        push("gap_restart", 64'b0001);
        push("gap_not_done", 64'b1110);
        tick();
        t_done = 4'b0000;
        pop_chk(64'(t_start));
        pop_chk(64'(is_done));
        t_ready = 4'b0001;
        tick();
        t_ready = 4'b0000;
        t_done  = 4'b0001;
        push("gap_final_done", 64'b1111);
        tick();
        t_done = 4'b0000;
        pop_chk(64'(is_done));
        g_done = 1'b1;
        tick();
        g_done = 1'b0;

        // back-to-back, iters=3, ready and done tied high
        g_mask  = 4'b1111;
        g_iters = 16'd3;
        t_ready = 4'b1111;
        t_done  = 4'b1111;
        g_start = 1'b1;
        tick();
        g_start = 1'b0;
        push("b2b_start_cycles", 64'd3);
        n_start = 0;
        for (int k = 0; k < 8; k++) begin
            if (t_start[0]) n_start++;
            tick();
        end
        pop_chk(64'(n_start));
        push("b2b_all_done", 64'h1);
        pop_chk(64'(all_done));
`ifdef TASK_FSM_PERF_EN
        push("b2b_busy", 64'd3);
        pop_chk(64'(busy[31:0]));
`endif
        t_ready = '0;
        t_done  = '0;
        g_done  = 1'b1;
        tick();
        g_done = 1'b0;

        // mask 0101, iters=2
        g_mask  = 4'b0101;
        g_iters = 16'd2;
        g_start = 1'b1;
        push("mask_start", 64'b0101);
        push("mask_skip_done", 64'b1010);
        tick();
        g_start = 1'b0;
        pop_chk(64'(t_start));
        pop_chk(64'(is_done));
        t_ready  = 4'b1111;
        t_done   = 4'b1111;
        start_or = '0;
        for (int k = 0; k < 6; k++) begin
            start_or = start_or | t_start;
            tick();
        end
        push("mask_never_start", 64'b0000);
        push("mask_all_done", 64'h1);
        pop_chk(64'(start_or & 4'b1010));
        pop_chk(64'(all_done));
        t_ready = '0;
        t_done  = '0;
        g_done  = 1'b1;
        tick();
        g_done = 1'b0;

        // zero iterations: everything done without starting
        g_mask  = 4'b1111;
        g_iters = 16'd0;
        g_start = 1'b1;
        push("zero_start", 64'b0000);
        push("zero_is_done", 64'b1111);
        push("zero_all_done", 64'h1);
        tick();
        g_start = 1'b0;
        pop_chk(64'(t_start));
        pop_chk(64'(is_done));
        pop_chk(64'(all_done));
        g_done = 1'b1;
        tick();
        g_done = 1'b0;

        // mid-run asynchronous reset
        g_mask         = 4'b0011;
        g_iters        = 16'd2;
        g_scalar[63:0] = 64'h0000_0000_CAFE_F00D;
        g_start        = 1'b1;
        tick();
        g_start = 1'b0;
        t_ready = 4'b0001;
        push("mr_pre_start", 64'b0010);
        push("mr_pre_done", 64'b1100);
        tick();
        t_ready = 4'b0000;
        pop_chk(64'(t_start));
        pop_chk(64'(is_done));
        #2;
        ap_rst = 1'b1;
        #1;
        push("mr_start", 64'b0000);
        push("mr_is_done", 64'b0000);
        push("mr_all_done", 64'h0);
        push("mr_scalar", 64'h0);
        pop_chk(64'(t_start));
        pop_chk(64'(is_done));
        pop_chk(64'(all_done));
        pop_chk(t_scalar[63:0]);
        tick();
        ap_rst = 1'b0;
        g_mask  = 4'b1111;
        g_iters = 16'd1;
        t_ready = 4'b1111;
        t_done  = 4'b1111;
        g_start = 1'b1;
        push("mr_restart", 64'b1111);
        tick();
        g_start = 1'b0;
        pop_chk(64'(t_start));
        push("mr_rerun_done", 64'h1);
        tick();
        pop_chk(64'(all_done));

        // simultaneous start and done while in DONE
        t_ready = '0;
        t_done  = '0;
        g_start = 1'b1;
        g_done  = 1'b1;
        push("sim_no_start", 64'b0000);
        push("sim_idle", 64'b0000);
        tick();
        g_done = 1'b0;
        pop_chk(64'(t_start));
        pop_chk(64'(is_done));
        push("sim_start_next", 64'b1111);
        tick();
        g_start = 1'b0;
        pop_chk(64'(t_start));
        t_ready = 4'b1111;
        t_done  = 4'b1111;
        push("sim_finish", 64'h1);
        tick();
        t_ready = '0;
        t_done  = '0;
        pop_chk(64'(all_done));

        chk("sb_leftover", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
